operand_lfsr_gen: RTL and testbench
===================================

// Module: operand_lfsr_gen
// PURPOSE
//   Sequential operand source for the 5-bit bitwise gate array (logic_gates).
//   Two independent LFSRs produce the a/b operand pair, one vector per accepted handshake.
//   The burst length is NUM_VECTORS; a burst is triggered by start and is reproducible from the seeds.
//   Sits directly upstream of logic_gates: a_o/b_o drive its a/b inputs; the consumer's ready paces it.
// PARAMETERS
//   WIDTH        5        operand width in bits (logic_gates is 5 bits)
//   TAPS         5'b10100 Fibonacci feedback mask (x^5+x^3+1, maximal length 31)
//   SEED_A       5'h01    reset/restart value of the a-LFSR
//   SEED_B       5'h1E    reset/restart value of the b-LFSR
//   NUM_VECTORS  5        vectors per burst, legal range 1..255
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset
//   start    in   1      begin a burst; sampled only in IDLE or DONE
//   ready_i  in   1      consumer can accept the current vector
//   valid_o  out  1      a_o/b_o hold a valid vector
//   a_o      out  WIDTH  operand a
//   b_o      out  WIDTH  operand b
//   index_o  out  8      index of the current vector within the burst, 0..NUM_VECTORS-1
//   busy_o   out  1      high in RUN
//   done_o   out  1      high in DONE, until the next start or rst
// BEHAVIOUR
//   Reset (rst=1 at a clk edge)
//     - state=IDLE; valid_o=0, busy_o=0, done_o=0, index_o=0.
//     - a_o=0, b_o=0; internal LFSRs load their seeds.
//     - Reset mid-burst aborts immediately; no partial-burst state is kept.
//   LFSR step
//     - fb = ^(lfsr & TAPS); next = {lfsr[WIDTH-2:0], fb}.
//     - A zero seed is replaced by 1, so an LFSR never locks at zero.
//   FSM: IDLE -> RUN -> DONE
//     - IDLE, start=1: load both seeds. Next cycle: RUN, valid_o=1, a_o=SEED_A, b_o=SEED_B, index_o=0.
//       Latency start->valid is 1 cycle.
//     - RUN, transfer (valid_o && ready_i at the edge):
//       - Both LFSRs step; index_o increments.
//       - The next vector appears on the following cycle; valid_o stays 1.
//       - Back-to-back transfers sustain 1 vector/cycle.
//     - RUN, valid_o && !ready_i: a_o, b_o and index_o hold stable. valid_o never drops without a transfer.
//     - RUN, transfer with index_o==NUM_VECTORS-1:
//       - Next state DONE; valid_o=0, busy_o=0, done_o=1.
//       - a_o/b_o keep the last vector; index_o holds.
//     - DONE, start=1: behaves exactly as IDLE+start (seeds reload, done_o=0, burst repeats identically).
//   Priorities and start handling
//     - start during RUN is ignored.
//     - rst has priority over start and over a transfer in the same cycle.
//   ready_i while valid_o=0 has no effect.
// TESTING
//   1. rst for 2 cycles, then idle -> valid_o=0, a_o=0, b_o=0, busy_o=0, done_o=0, index_o=0.
//   2. start, ready_i=1 constantly -> valid_o 1 cycle after start.
//      a_o = 1,2,4,9,18 and b_o = 30,28,24,17,3 on consecutive cycles; index_o 0..4.
//      Then done_o=1, valid_o=0.
//   3. start, ready_i low for 3 cycles on vector index 1 -> a_o=2, b_o=30-step value (28) held;
//      valid_o stays 1 for all 3 cycles; the sequence resumes unchanged.
//   4. start pulsed mid-burst at index 2 -> ignored; the burst still ends after exactly 5 transfers.
//   5. rst asserted at index 3 -> next cycle IDLE with all outputs 0.
//      A new start replays from a_o=1, b_o=30.
//   6. start in DONE -> done_o clears; an identical 5-vector burst is produced.
//      With SEED_A=0: a_o sequence starts at 1.

Source files
------------

// File: rtl/operand_lfsr_gen.sv
// Burst operand source for the logic_gates block: two Fibonacci LFSRs emit an a/b
// pair per valid/ready transfer, NUM_VECTORS pairs per start, replayable from the seeds.
module operand_lfsr_gen #(
    parameter int               WIDTH       = 5,
    parameter logic [WIDTH-1:0] TAPS        = 5'b10100,
    parameter logic [WIDTH-1:0] SEED_A      = 5'h01,
    parameter logic [WIDTH-1:0] SEED_B      = 5'h1E,
    parameter int               NUM_VECTORS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [7:0]       index_o,
    output logic             busy_o,
    output logic             done_o
);

    // A zero seed would lock the LFSR at zero forever, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_A_NZ  = (SEED_A == '0) ? WIDTH'(1) : SEED_A;
    localparam logic [WIDTH-1:0] SEED_B_NZ  = (SEED_B == '0) ? WIDTH'(1) : SEED_B;
    localparam logic [7:0]       LAST_INDEX = 8'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ^(v & TAPS)};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] lfsr_a_q, lfsr_b_q;
    logic [7:0]       index_q;
    logic             transfer;
    logic             last_transfer;
    logic             launch;

    assign transfer      = (state_q == RUN) && ready_i;
    assign last_transfer = transfer && (index_q == LAST_INDEX);
    assign launch        = (state_q != RUN) && start;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_transfer) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so all of them update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // lfsr_*_q always holds the vector that follows the one on a_o/b_o, so a transfer
    // only has to copy it across and advance the lookahead by one step.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            lfsr_a_q <= SEED_A_NZ;
            lfsr_b_q <= SEED_B_NZ;
            index_q  <= '0;
        end else if (launch) begin
            a_q      <= SEED_A_NZ;
            b_q      <= SEED_B_NZ;
            lfsr_a_q <= lfsr_step(SEED_A_NZ);
            lfsr_b_q <= lfsr_step(SEED_B_NZ);
            index_q  <= '0;
        end else if (transfer && !last_transfer) begin
            a_q      <= lfsr_a_q;
            b_q      <= lfsr_b_q;
            lfsr_a_q <= lfsr_step(lfsr_a_q);
            lfsr_b_q <= lfsr_step(lfsr_b_q);
            index_q  <= index_q + 8'd1;
        end
    end

    assign valid_o = (state_q == RUN);
    assign busy_o  = (state_q == RUN);
    assign done_o  = (state_q == DONE);
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign index_o = index_q;

endmodule

// File: tb/tb_operand_lfsr_gen.sv
// Self-checking bench for operand_lfsr_gen: directed scenarios plus randomized ready
// back-pressure, checked against an arithmetic model of the LFSR sequence.
module tb_operand_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       ready;
    logic       valid0, busy0, done0;
    logic [4:0] a0, b0;
    logic [7:0] idx0;
    logic       valid1, busy1, done1;
    logic [4:0] a1, b1;
    logic [7:0] idx1;

    int checks = 0;
    int errors = 0;
    int exp_a[$];
    int exp_b[$];

    always #5 clk = ~clk;

    operand_lfsr_gen u_dut (
        .clk(clk), .rst(rst), .start(start), .ready_i(ready),
        .valid_o(valid0), .a_o(a0), .b_o(b0), .index_o(idx0),
        .busy_o(busy0), .done_o(done0)
    );

    // Zero seed for a and a single-vector burst.
    operand_lfsr_gen #(.SEED_A(5'h00), .NUM_VECTORS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .ready_i(ready),
        .valid_o(valid1), .a_o(a1), .b_o(b1), .index_o(idx1),
        .busy_o(busy1), .done_o(done1)
    );

    // x^5+x^3+1 Fibonacci step: shift left by doubling, feedback = parity of bits 4 and 2.
    function automatic int model_next(input int v);
        int p;
        p = ((v / 16) % 2) + ((v / 4) % 2);
        return (v * 2 + (p % 2)) % 32;
    endfunction

    task automatic build_model(input int seed_a, input int seed_b, input int n);
        int va, vb;
        va = (seed_a == 0) ? 1 : seed_a;
        vb = (seed_b == 0) ? 1 : seed_b;
        exp_a.delete();
        exp_b.delete();
        for (int i = 0; i < n; i++) begin
            exp_a.push_back(va);
            exp_b.push_back(vb);
            va = model_next(va);
            vb = model_next(vb);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic launch();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid0); end
        checks++; if (a0 !== 5'd0) begin errors++; $display("FAIL reset_a: got %0d want 0", a0); end
        checks++; if (b0 !== 5'd0) begin errors++; $display("FAIL reset_b: got %0d want 0", b0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done0); end
        checks++; if (idx0 !== 8'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", idx0); end
    endtask

    task automatic test_basic_burst();
        int ca[5] = '{1, 2, 4, 9, 18};
        int cb[5] = '{30, 28, 24, 17, 3};
        ready = 1'b1;
        launch();
        for (int i = 0; i < 5; i++) begin
            checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b want 1", i, valid0); end
            checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d]: got %b want 1", i, busy0); end
            checks++; if (int'(a0) != ca[i]) begin errors++; $display("FAIL basic_a[%0d]: got %0d want %0d", i, a0, ca[i]); end
            checks++; if (int'(b0) != cb[i]) begin errors++; $display("FAIL basic_b[%0d]: got %0d want %0d", i, b0, cb[i]); end
            checks++; if (int'(idx0) != i) begin errors++; $display("FAIL basic_index[%0d]: got %0d want %0d", i, idx0, i); end
            cycle();
        end
        repeat (2) begin
            checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done0); end
            checks++; if (valid0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL basic_end_valid_busy: got %b%b want 00", valid0, busy0); end
            checks++; if (a0 !== 5'd18 || b0 !== 5'd3) begin errors++; $display("FAIL basic_hold_last: got a=%0d b=%0d want a=18 b=3", a0, b0); end
            checks++; if (idx0 !== 8'd4) begin errors++; $display("FAIL basic_hold_index: got %0d want 4", idx0); end
            cycle();
        end
    endtask

    task automatic test_stall();
        build_model(1, 30, 5);
        ready = 1'b1;
        launch();
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL stall_done_clear: got %b want 0", done0); end
        cycle();
        ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            cycle();
            checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", s, valid0); end
            checks++; if (a0 !== 5'd2 || b0 !== 5'd28) begin errors++; $display("FAIL stall_hold[%0d]: got a=%0d b=%0d want a=2 b=28", s, a0, b0); end
            checks++; if (idx0 !== 8'd1) begin errors++; $display("FAIL stall_index[%0d]: got %0d want 1", s, idx0); end
        end
        ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++; if (int'(a0) != exp_a[i] || int'(b0) != exp_b[i] || int'(idx0) != i)
                begin errors++; $display("FAIL stall_resume[%0d]: got a=%0d b=%0d idx=%0d want a=%0d b=%0d idx=%0d", i, a0, b0, idx0, exp_a[i], exp_b[i], i); end
            cycle();
        end
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL stall_end_done: got %b want 1", done0); end
    endtask

    task automatic test_start_ignored();
        int n;
        build_model(1, 30, 5);
        ready = 1'b1;
        launch();
        n = 0;
        for (int c = 0; c < 20 && valid0 === 1'b1; c++) begin
            checks++; if (int'(a0) != exp_a[n] || int'(b0) != exp_b[n] || int'(idx0) != n)
                begin errors++; $display("FAIL ignore_seq[%0d]: got a=%0d b=%0d idx=%0d want a=%0d b=%0d idx=%0d", n, a0, b0, idx0, exp_a[n], exp_b[n], n); end
            start = (n == 2);
            cycle();
            start = 1'b0;
            n++;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL ignore_count: got %0d transfers want 5", n); end
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b want 1", done0); end
    endtask

    task automatic test_reset_mid();
        ready = 1'b1;
        launch();
        repeat (3) cycle();
        checks++; if (idx0 !== 8'd3) begin errors++; $display("FAIL midrst_pre_index: got %0d want 3", idx0); end
        rst = 1'b1;
        start = 1'b1;
        cycle();
        rst = 1'b0;
        start = 1'b0;
        checks++; if ({valid0, busy0, done0} !== 3'b000) begin errors++; $display("FAIL midrst_flags: got %b want 000", {valid0, busy0, done0}); end
        checks++; if (a0 !== 5'd0 || b0 !== 5'd0 || idx0 !== 8'd0) begin errors++; $display("FAIL midrst_data: got a=%0d b=%0d idx=%0d want 0 0 0", a0, b0, idx0); end
        cycle();
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL midrst_stays_idle: got %b want 0", valid0); end
        launch();
        checks++; if (a0 !== 5'd1 || b0 !== 5'd30 || idx0 !== 8'd0 || valid0 !== 1'b1)
            begin errors++; $display("FAIL midrst_replay: got a=%0d b=%0d idx=%0d v=%b want 1 30 0 1", a0, b0, idx0, valid0); end
        repeat (5) cycle();
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL midrst_replay_done: got %b want 1", done0); end
    endtask

    task automatic test_restart_and_zero_seed();
        build_model(1, 30, 5);
        ready = 1'b1;
        launch();
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL restart_done_clear: got %b want 0", done0); end
        checks++; if (valid1 !== 1'b1 || a1 !== 5'd1 || b1 !== 5'd30 || idx1 !== 8'd0)
            begin errors++; $display("FAIL zseed_first: got v=%b a=%0d b=%0d idx=%0d want 1 1 30 0", valid1, a1, b1, idx1); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (int'(a0) != exp_a[i] || int'(b0) != exp_b[i] || int'(idx0) != i)
                begin errors++; $display("FAIL restart_seq[%0d]: got a=%0d b=%0d idx=%0d want a=%0d b=%0d idx=%0d", i, a0, b0, idx0, exp_a[i], exp_b[i], i); end
            cycle();
            if (i == 0) begin
                checks++; if (done1 !== 1'b1 || valid1 !== 1'b0 || a1 !== 5'd1)
                    begin errors++; $display("FAIL zseed_single: got d=%b v=%b a=%0d want 1 0 1", done1, valid1, a1); end
            end
        end
        checks++; if (done0 !== 1'b1 || valid0 !== 1'b0) begin errors++; $display("FAIL restart_end: got d=%b v=%b want 1 0", done0, valid0); end
    endtask

    task automatic test_random_backpressure();
        logic xfer;
        int   k;
        build_model(1, 30, 5);
        for (int burst = 0; burst < 4; burst++) begin
            launch();
            k = 0;
            for (int c = 0; c < 200 && k < 5; c++) begin
                checks++; if (valid0 !== 1'b1 || int'(a0) != exp_a[k] || int'(b0) != exp_b[k] || int'(idx0) != k)
                    begin errors++; $display("FAIL rand_vec[%0d.%0d]: got v=%b a=%0d b=%0d idx=%0d want 1 %0d %0d %0d", burst, k, valid0, a0, b0, idx0, exp_a[k], exp_b[k], k); end
                ready = 1'($urandom_range(0, 1));
                xfer = ready;
                cycle();
                if (xfer) k++;
            end
            checks++; if (k != 5) begin errors++; $display("FAIL rand_timeout[%0d]: got %0d transfers want 5", burst, k); end
            checks++; if (done0 !== 1'b1 || valid0 !== 1'b0) begin errors++; $display("FAIL rand_done[%0d]: got d=%b v=%b want 1 0", burst, done0, valid0); end
            ready = 1'b1;
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_restart_and_zero_seed();
        test_random_backpressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
